// File: rtl/wired_commit_select.sv
`default_nettype none
// ============================================================================
// Module   : wired_commit_select
// Brief    : N-wide commit retire-select (F stage) with one-deep skid to H
// Revision : 1.0 - initial release
// ============================================================================
module wired_commit_select #(
  parameter int COMMIT_WIDTH = 2,
  parameter int ROB_LEN      = 6,
  parameter int PAYLOAD_W    = 128,
  parameter int BANK_BITS    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic [COMMIT_WIDTH*ROB_LEN-1:0] c_rrrid_o,
  input  logic [COMMIT_WIDTH-1:0]         c_rob_valid_i,
  input  logic [COMMIT_WIDTH*PAYLOAD_W-1:0] c_rob_payload_i,
  input  logic [COMMIT_WIDTH-1:0]         c_rob_slot0_i,
  input  logic [COMMIT_WIDTH-1:0]         c_rob_wen_i,
  input  logic [COMMIT_WIDTH*BANK_BITS-1:0] c_rob_wbank_i,
  output logic [COMMIT_WIDTH-1:0]         c_retire_o,
  output logic [COMMIT_WIDTH-1:0]         h_valid_o,
  output logic [COMMIT_WIDTH*PAYLOAD_W-1:0] h_payload_o,
  output logic [COMMIT_WIDTH*ROB_LEN-1:0] h_rrid_o,
  input  logic                            h_ready_i,
  input  logic                            flush_i,
  output logic [31:0]                     stat_retired_o
);

  localparam int c_W = COMMIT_WIDTH;

  logic [ROB_LEN-1:0]         r_ptr;
  logic                       r_skid_full;
  logic [c_W-1:0]             r_skid_sel;
  logic [c_W*PAYLOAD_W-1:0]   r_skid_payload;
  logic [c_W*ROB_LEN-1:0]     r_skid_rrid;
  logic [31:0]                r_retired;

  logic [c_W-1:0]             w_conflict;
  logic [c_W-1:0]             w_sel;
  logic [c_W-1:0]             w_retire;
  logic [c_W*ROB_LEN-1:0]     w_rrid;
  logic [31:0]                w_retire_cnt;
  logic                       w_active;

  // Reset is folded in so the combinational outputs are quiet while rst_n is low.
  assign w_active = rst_n & ~flush_i;

  always_comb begin
    w_rrid = '0;
    for (int i = 0; i < c_W; i++)
      w_rrid[i*ROB_LEN +: ROB_LEN] = r_ptr + ROB_LEN'(i);
  end

  // Lane i conflicts if it shares a write bank with any older lane in the group.
  always_comb begin
    w_conflict = '0;
    for (int i = 1; i < c_W; i++)
      for (int j = 0; j < i; j++)
        if (c_rob_wen_i[i] && c_rob_wen_i[j] &&
            (c_rob_wbank_i[i*BANK_BITS +: BANK_BITS] == c_rob_wbank_i[j*BANK_BITS +: BANK_BITS]))
          w_conflict[i] = 1'b1;
  end

  always_comb begin : p_select
    logic v_run;
    w_sel    = '0;
    v_run    = c_rob_valid_i[0];
    w_sel[0] = v_run;
    for (int i = 1; i < c_W; i++) begin
      v_run    = v_run & c_rob_valid_i[i] & ~c_rob_slot0_i[i] & ~c_rob_slot0_i[0] & ~w_conflict[i];
      w_sel[i] = v_run;
    end
  end

  always_comb begin
    w_retire    = '0;
    h_valid_o   = '0;
    h_payload_o = c_rob_payload_i;
    h_rrid_o    = w_rrid;
    if (r_skid_full) begin
      h_payload_o = r_skid_payload;
      h_rrid_o    = r_skid_rrid;
      if (w_active) h_valid_o = r_skid_sel;
    end else if (w_active) begin
      w_retire  = w_sel;
      h_valid_o = w_sel;
    end
  end

  always_comb begin
    w_retire_cnt = '0;
    for (int i = 0; i < c_W; i++)
      w_retire_cnt = w_retire_cnt + 32'(w_retire[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr          <= '0;
      r_skid_full    <= 1'b0;
      r_skid_sel     <= '0;
      r_skid_payload <= '0;
      r_skid_rrid    <= '0;
      r_retired      <= '0;
    end else begin
      r_retired <= r_retired + w_retire_cnt;
      if (flush_i) begin
        r_ptr       <= '0;
        r_skid_full <= 1'b0;
        r_skid_sel  <= '0;
      end else begin
        r_ptr <= r_ptr + w_retire_cnt[ROB_LEN-1:0];
        if (r_skid_full) begin
          // Release only; the next ROB group is presented from the following cycle.
          if (h_ready_i) begin
            r_skid_full <= 1'b0;
            r_skid_sel  <= '0;
          end
        end else if ((|w_sel) && !h_ready_i) begin
          r_skid_full    <= 1'b1;
          r_skid_sel     <= w_sel;
          r_skid_payload <= c_rob_payload_i;
          r_skid_rrid    <= w_rrid;
        end
      end
    end
  end

  assign c_rrrid_o      = w_rrid;
  assign c_retire_o     = w_retire;
  assign stat_retired_o = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wired_commit_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_wired_commit_select
// Brief    : Directed self-checking bench for wired_commit_select (W=2 and W=4)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wired_commit_select;

  localparam int c_W  = 2;
  localparam int c_RL = 6;
  localparam int c_PW = 16;
  localparam int c_W4 = 4;
  localparam int c_B4 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [c_W*c_RL-1:0] a_rrrid, a_hrrid;
  logic [c_W-1:0]      a_valid, a_slot0, a_wen, a_wbank, a_retire, a_hvalid;
  logic [c_W*c_PW-1:0] a_payload, a_hpay;
  logic                a_ready, a_flush;
  logic [31:0]         a_stat;

  logic [c_W4*c_RL-1:0] b_rrrid, b_hrrid;
  logic [c_W4-1:0]      b_valid, b_slot0, b_wen, b_retire, b_hvalid;
  logic [c_W4*c_B4-1:0] b_wbank;
  logic [c_W4*c_PW-1:0] b_payload, b_hpay;
  logic                 b_ready, b_flush;
  logic [31:0]          b_stat;

  wired_commit_select #(.COMMIT_WIDTH(c_W), .ROB_LEN(c_RL), .PAYLOAD_W(c_PW), .BANK_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .c_rrrid_o(a_rrrid), .c_rob_valid_i(a_valid),
    .c_rob_payload_i(a_payload), .c_rob_slot0_i(a_slot0), .c_rob_wen_i(a_wen),
    .c_rob_wbank_i(a_wbank), .c_retire_o(a_retire), .h_valid_o(a_hvalid),
    .h_payload_o(a_hpay), .h_rrid_o(a_hrrid), .h_ready_i(a_ready),
    .flush_i(a_flush), .stat_retired_o(a_stat)
  );

  wired_commit_select #(.COMMIT_WIDTH(c_W4), .ROB_LEN(c_RL), .PAYLOAD_W(c_PW), .BANK_BITS(c_B4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .c_rrrid_o(b_rrrid), .c_rob_valid_i(b_valid),
    .c_rob_payload_i(b_payload), .c_rob_slot0_i(b_slot0), .c_rob_wen_i(b_wen),
    .c_rob_wbank_i(b_wbank), .c_retire_o(b_retire), .h_valid_o(b_hvalid),
    .h_payload_o(b_hpay), .h_rrid_o(b_hrrid), .h_ready_i(b_ready),
    .flush_i(b_flush), .stat_retired_o(b_stat)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  slot0;
    logic [1:0]  wen;
    logic [1:0]  wbank;
    logic [1:0]  exp_retire;
    logic [5:0]  exp_ptr;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vec [9];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [1:0] v, logic [1:0] s, logic [1:0] w, logic [1:0] b,
                              logic [1:0] r, logic [5:0] p, logic [31:0] c);
    vec_t t;
    t.valid = v; t.slot0 = s; t.wen = w; t.wbank = b;
    t.exp_retire = r; t.exp_ptr = p; t.exp_cnt = c;
    return t;
  endfunction

  function automatic logic [15:0] pay(int k, int lane);
    return 16'hA000 | 16'(k << 4) | 16'(lane);
  endfunction

  // Lane 1 id in the upper half, lane 0 id in the lower half.
  function automatic logic [11:0] rr2(logic [5:0] p);
    logic [5:0] p1;
    p1 = p + 6'd1;
    return {p1, p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] prev_ptr;
    logic [31:0] p_old, p_new;

    vec[0] = mk(2'b11, 2'b00, 2'b11, 2'b10, 2'b11, 6'd2, 32'd2);  // independent
    vec[1] = mk(2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 6'd3, 32'd3);  // bank conflict
    vec[2] = mk(2'b11, 2'b01, 2'b11, 2'b10, 2'b01, 6'd4, 32'd4);  // slot0 lane 0
    vec[3] = mk(2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 6'd5, 32'd5);  // slot0 lane 1
    vec[4] = mk(2'b11, 2'b01, 2'b11, 2'b10, 2'b01, 6'd6, 32'd6);  // that entry now lane 0
    vec[5] = mk(2'b10, 2'b00, 2'b11, 2'b10, 2'b00, 6'd6, 32'd6);  // lane 0 not ready
    vec[6] = mk(2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 6'd7, 32'd7);
    vec[7] = mk(2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 6'd9, 32'd9);  // same bank, one wen
    vec[8] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'd9, 32'd9);

    a_valid = 2'b11; a_slot0 = '0; a_wen = 2'b11; a_wbank = 2'b10;
    a_payload = '0; a_ready = 1'b1; a_flush = 1'b0;
    b_valid = '0; b_slot0 = '0; b_wen = '0; b_wbank = '0;
    b_payload = '0; b_ready = 1'b1; b_flush = 1'b0;

    #1;
    check("reset_retire", 64'(a_retire), 64'd0);
    check("reset_hvalid", 64'(a_hvalid), 64'd0);
    check("reset_stat", 64'(a_stat), 64'd0);
    check("reset_rrrid", 64'(a_rrrid), 64'(rr2(6'd0)));
    check("reset_rrrid_w4", 64'(b_rrrid), 64'({6'd3, 6'd2, 6'd1, 6'd0}));

    @(negedge clk);
    rst_n = 1'b1;
    a_valid = '0;
    prev_ptr = 6'd0;

    for (int k = 0; k < 9; k++) begin
      a_valid = vec[k].valid; a_slot0 = vec[k].slot0;
      a_wen = vec[k].wen; a_wbank = vec[k].wbank; a_ready = 1'b1;
      a_payload = {pay(k, 1), pay(k, 0)};
      #1;
      check($sformatf("v%0d_retire", k), 64'(a_retire), 64'(vec[k].exp_retire));
      check($sformatf("v%0d_hvalid", k), 64'(a_hvalid), 64'(vec[k].exp_retire));
      if (vec[k].exp_retire[0]) begin
        check($sformatf("v%0d_hpay0", k), 64'(a_hpay[15:0]), 64'(pay(k, 0)));
        check($sformatf("v%0d_hrrid0", k), 64'(a_hrrid[5:0]), 64'(prev_ptr));
      end
      tick();
      check($sformatf("v%0d_rrrid", k), 64'(a_rrrid), 64'(rr2(vec[k].exp_ptr)));
      check($sformatf("v%0d_stat", k), 64'(a_stat), 64'(vec[k].exp_cnt));
      prev_ptr = vec[k].exp_ptr;
    end

    // Skid hold: ptr=9, count=9
    p_old = {16'hB001, 16'hB000};
    p_new = {16'hC001, 16'hC000};
    a_valid = 2'b11; a_slot0 = '0; a_wen = 2'b11; a_wbank = 2'b10;
    a_payload = p_old; a_ready = 1'b0;
    #1;
    check("skid_capture_retire", 64'(a_retire), 64'b11);
    tick();
    a_payload = p_new;
    #1;
    check("skid_hold_retire", 64'(a_retire), 64'd0);
    check("skid_hold_hvalid", 64'(a_hvalid), 64'b11);
    check("skid_hold_hpay", 64'(a_hpay), 64'(p_old));
    check("skid_hold_hrrid", 64'(a_hrrid), 64'(rr2(6'd9)));
    check("skid_hold_rrrid", 64'(a_rrrid), 64'(rr2(6'd11)));
    check("skid_hold_stat", 64'(a_stat), 64'd11);
    tick();
    check("skid_hold2_retire", 64'(a_retire), 64'd0);
    check("skid_hold2_hpay", 64'(a_hpay), 64'(p_old));
    check("skid_hold2_rrrid", 64'(a_rrrid), 64'(rr2(6'd11)));
    a_ready = 1'b1;
    #1;
    check("skid_release_hvalid", 64'(a_hvalid), 64'b11);
    check("skid_release_hpay", 64'(a_hpay), 64'(p_old));
    check("skid_release_retire", 64'(a_retire), 64'd0);
    tick();
    check("skid_next_hvalid", 64'(a_hvalid), 64'b11);
    check("skid_next_hpay", 64'(a_hpay), 64'(p_new));
    check("skid_next_hrrid", 64'(a_hrrid), 64'(rr2(6'd11)));
    check("skid_next_retire", 64'(a_retire), 64'b11);
    check("skid_next_stat", 64'(a_stat), 64'd11);
    tick();
    check("skid_after_stat", 64'(a_stat), 64'd13);
    check("skid_after_rrrid", 64'(a_rrrid), 64'(rr2(6'd13)));

    // Wrap: 25 more double retires take ptr 13 -> 63
    for (int n = 0; n < 25; n++) tick();
    check("wrap_rrrid", 64'(a_rrrid), 64'({6'd0, 6'd63}));
    check("wrap_stat", 64'(a_stat), 64'd63);
    a_ready = 1'b0;
    #1;
    check("wrap_retire", 64'(a_retire), 64'b11);
    tick();
    check("wrap_ptr1", 64'(a_rrrid), 64'(rr2(6'd1)));
    check("wrap_stat2", 64'(a_stat), 64'd65);
    check("wrap_skid_hrrid", 64'(a_hrrid), 64'({6'd0, 6'd63}));

    // Flush with skid full
    a_flush = 1'b1; a_ready = 1'b1;
    #1;
    check("flush_hvalid", 64'(a_hvalid), 64'd0);
    check("flush_retire", 64'(a_retire), 64'd0);
    tick();
    a_flush = 1'b0; a_valid = 2'b00;
    #1;
    check("post_flush_hvalid", 64'(a_hvalid), 64'd0);
    check("post_flush_rrrid", 64'(a_rrrid), 64'(rr2(6'd0)));
    check("post_flush_stat", 64'(a_stat), 64'd65);

    // Async reset while the skid holds a group
    a_valid = 2'b11; a_ready = 1'b0;
    tick();
    check("pre_rst_hvalid", 64'(a_hvalid), 64'b11);
    check("pre_rst_stat", 64'(a_stat), 64'd67);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hvalid", 64'(a_hvalid), 64'd0);
    check("async_rst_retire", 64'(a_retire), 64'd0);
    check("async_rst_stat", 64'(a_stat), 64'd0);
    check("async_rst_rrrid", 64'(a_rrrid), 64'(rr2(6'd0)));
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 2'b00;
    #1;
    check("post_rst_hvalid", 64'(a_hvalid), 64'd0);

    // W=4 prefix break: banks lane0..3 = {0,1,0,2}; lane 2 hits lane 0
    b_valid = 4'b1111; b_wen = 4'b1111; b_slot0 = '0;
    b_wbank = {2'd2, 2'd0, 2'd1, 2'd0};
    b_ready = 1'b1;
    #1;
    check("w4_retire", 64'(b_retire), 64'b0011);
    check("w4_hvalid", 64'(b_hvalid), 64'b0011);
    tick();
    check("w4_rrrid", 64'(b_rrrid), 64'({6'd5, 6'd4, 6'd3, 6'd2}));
    check("w4_stat", 64'(b_stat), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wired_commit_select.md
Name: wired_commit_select

Overview:
- Parametrised N-wide retire-select front stage of the commit pipeline: the F stage between the ROB read ports and the commit handler (H stage).
- Each cycle it reads up to COMMIT_WIDTH in-order ROB entries and picks the longest legal prefix to retire.
- Retired entries pass through a one-deep skid buffer to H. The ROB pointer advances by the retire count.
- Generalises the fixed 2-wide selector to N lanes: prefix rules, all-pairs bank-conflict check, slot0-exclusive retirement, flush, and a retire counter.

Parameters:
- COMMIT_WIDTH, 2, number of retire lanes (1..4).
- ROB_LEN, 6, ROB index width; ROB depth is 2^ROB_LEN.
- PAYLOAD_W, 128, opaque ROB entry payload width.
- BANK_BITS, 1, width of the destination-register bank field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- c_rrrid_o  out  COMMIT_WIDTH*ROB_LEN  ROB read ids; lane i = (ptr + i) mod 2^ROB_LEN
- c_rob_valid_i  in  COMMIT_WIDTH  lane i entry complete and ready to retire
- c_rob_payload_i  in  COMMIT_WIDTH*PAYLOAD_W  entry payload per lane
- c_rob_slot0_i  in  COMMIT_WIDTH  entry must retire alone in lane 0 (CSR, uncached, store, flush-causing)
- c_rob_wen_i  in  COMMIT_WIDTH  entry writes an architectural register
- c_rob_wbank_i  in  COMMIT_WIDTH*BANK_BITS  destination register bank
- c_retire_o  out  COMMIT_WIDTH  lanes popped from the ROB this cycle
- h_valid_o  out  COMMIT_WIDTH  lanes presented to H
- h_payload_o  out  COMMIT_WIDTH*PAYLOAD_W  payloads presented to H
- h_rrid_o  out  COMMIT_WIDTH*ROB_LEN  ROB ids of the presented lanes
- h_ready_i  in  1  H accepts the presented group this cycle
- flush_i  in  1  pipeline flush; ROB is empty and restarts at index 0
- stat_retired_o  out  32  total entries retired since reset

Behaviour:
- Reset (async, rst_n=0):
  - ptr=0, skid empty, skid valid=0, counter=0.
  - Outputs: c_retire_o=0, h_valid_o=0, stat_retired_o=0, c_rrrid_o lane i = i.
- Selection, combinational, sel[i]:
  - sel[0] = valid[0].
  - sel[i], i>0, requires all of:
    - sel[i-1]
    - valid[i]
    - !slot0[i]
    - !slot0[0]
    - for every j<i: !(wen[i] && wen[j] && wbank[i]==wbank[j])
  - A slot0 entry in lane 0 always retires alone. A slot0 entry in lane i>0 waits until it reaches lane 0.
- Skid buffer, empty state:
  - h_* driven combinationally from ROB inputs and sel; latency 0.
  - c_retire_o = sel.
  - If |sel and !h_ready_i: capture sel, payloads and rrids into the skid; go full.
- Skid buffer, full state:
  - h_* driven from the skid registers; c_retire_o = 0.
  - On h_ready_i: go empty. No new capture in the same cycle; the next group is presented from cycle+1.
- Pointer and counter:
  - ptr advances by popcount(c_retire_o) each cycle, modulo 2^ROB_LEN (wraps 63->0 at ROB_LEN=6).
  - stat_retired_o += popcount(c_retire_o), wraps at 2^32.
- Flush:
  - flush_i=1: next cycle ptr=0, skid empty, skid valid=0.
  - c_retire_o is forced to 0 in the flush cycle.
  - h_valid_o is forced to 0 in the flush cycle.
  - Flush beats h_ready_i and capture in the same cycle. The counter is unaffected.
- Payloads: h_payload_o and h_rrid_o are don't-care where h_valid_o=0.

Test Plan:
- Independent entries. W=2, ptr=0, both lanes valid, slot0=0, wen=1, wbank 0 and 1, h_ready=1 -> c_retire_o=2'b11, h_valid_o=2'b11, next c_rrrid_o={3,2}, stat_retired_o=2.
- Bank conflict. Same as above with both wbank=0 -> c_retire_o=2'b01, next ptr=1.
- Slot0 in lane 0. slot0[0]=1 -> c_retire_o=2'b01.
- Slot0 in lane 1. slot0[1]=1 -> c_retire_o=2'b01; next cycle that entry sits in lane 0 and retires alone.
- Skid hold. W=2, both lanes retire with h_ready=0 -> c_retire_o=2'b11 for one cycle, then 0 while h_ready=0; h_payload_o holds the captured values. Raise h_ready -> released that cycle; new ROB group presented next cycle. Nothing lost or duplicated.
- Wrap and flush. ptr=63, W=2, both lanes retire -> c_rrrid_o={0,63} and ptr becomes 1. Then flush_i=1 with skid full -> h_valid_o=0 that cycle, ptr=0 and skid empty next cycle.
- W=4 prefix break. valid=4'b1111, wen=1, wbanks (BANK_BITS=2) {0,1,0,2} with lane0=0 -> lane 2 conflicts with lane 0 -> c_retire_o=4'b0011.
- Async reset mid-hold. rst_n pulsed low with skid full -> outputs clear immediately without a clock edge.
